// File: rtl/xgmii_pcs_tx_block_fsm_pkg.sv
// ---------------------------------------------------------------------------
// xgmii_pcs_tx_block_fsm_pkg
// Shared definitions for the XGMII-to-PCS transmit block classifier:
// XGMII control characters, the sequence FSM state encoding, the block
// class encoding and a helper that builds the terminate control mask.
// ---------------------------------------------------------------------------
package xgmii_pcs_tx_block_fsm_pkg;

    localparam int LANE_W = 8;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    typedef enum logic [1:0] {
        SEQ_INIT = 2'd0,
        SEQ_C    = 2'd1,
        SEQ_D    = 2'd2,
        SEQ_E    = 2'd3
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_DATA  = 3'd0,
        CLS_IDLE  = 3'd1,
        CLS_START = 3'd2,
        CLS_TERM  = 3'd3,
        CLS_ERR   = 3'd4
    } blk_class_e;

    // Control mask of a block terminated on lane k: lanes k..7 are control.
    function automatic logic [7:0] term_ctrl_mask(input logic [2:0] k);
        return 8'hFF << k;
    endfunction

endpackage

// File: rtl/xgmii_gearbox_32_64.sv
// ---------------------------------------------------------------------------
// xgmii_gearbox_32_64
// Pairs two consecutive valid 32-bit XGMII beats into one 64-bit block.
// The first beat supplies lanes 0-3, the second lanes 4-7. The completed
// block is presented combinationally in the cycle of the second beat.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset; discards a held first half
//   beat_v_i  beat valid
//   beat_d_i  beat data, lane 0 in bits [7:0]
//   beat_c_i  beat per-lane control flags
//   blk_v_o   block complete this cycle
//   blk_d_o   assembled block data (lanes 0-7)
//   blk_c_o   assembled block control flags
// ---------------------------------------------------------------------------
module xgmii_gearbox_32_64
    import xgmii_pcs_tx_block_fsm_pkg::*;
#(
    parameter int HALF_W = 32,
    parameter int HALF_C = HALF_W / LANE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  beat_v_i,
    input  logic [HALF_W-1:0]     beat_d_i,
    input  logic [HALF_C-1:0]     beat_c_i,
    output logic                  blk_v_o,
    output logic [2*HALF_W-1:0]   blk_d_o,
    output logic [2*HALF_C-1:0]   blk_c_o
);

    logic              half_q, half_d;
    logic [HALF_W-1:0] lo_d_q, lo_d_d;
    logic [HALF_C-1:0] lo_c_q, lo_c_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            half_q <= 1'b0;
            lo_d_q <= '0;
            lo_c_q <= '0;
        end else begin
            half_q <= half_d;
            lo_d_q <= lo_d_d;
            lo_c_q <= lo_c_d;
        end
    end

    always_comb begin
        half_d = half_q;
        lo_d_d = lo_d_q;
        lo_c_d = lo_c_q;
        if (beat_v_i) begin
            half_d = ~half_q;
            if (!half_q) begin
                lo_d_d = beat_d_i;
                lo_c_d = beat_c_i;
            end
        end
    end

    // Gated with reset so a beat arriving during reset never completes a block.
    assign blk_v_o = beat_v_i & half_q & ~reset;
    assign blk_d_o = {beat_d_i, lo_d_q};
    assign blk_c_o = {beat_c_i, lo_c_q};

endmodule

// File: rtl/xgmii_pcs_tx_block_fsm.sv
// ---------------------------------------------------------------------------
// xgmii_pcs_tx_block_fsm
// Classifies 64-bit XGMII blocks (data / idle / start / terminate / error)
// for the PCS transmit encoder and, optionally, checks the block sequence.
// 32-bit XGMII is assembled into blocks by xgmii_gearbox_32_64; 64-bit
// beats are used directly. All outputs are registered and update one cycle
// after the beat that completes a block; they hold between blocks.
//
// Optional feature: define PCS_TX_SEQ_CHECK_EN to build the sequence FSM.
// Without it the outputs are the pure block classification and seq_err_o=0.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   xgmii_v_i      XGMII beat valid
//   xgmii_txd_i    XGMII data, lane 0 in bits [7:0]
//   xgmii_txc_i    XGMII per-lane control flags
//   block_v_o      one-cycle pulse, block outputs valid
//   data_v_o .. err_v_o  block class flags (ctrl_v_o = any control lane)
//   start_lane4_o  start character on lane 4
//   term_lane_o    lane holding the terminate character
//   keep_o         data-byte mask
//   seq_err_o      illegal block sequence (pulses with block_v_o)
//
// Sequence FSM (PCS_TX_SEQ_CHECK_EN)
//   state | meaning
//   INIT  | after reset, no block seen yet
//   C     | between frames (idle / terminate seen)
//   D     | inside a frame (start / data seen)
//   E     | illegal sequence or error block seen
// ---------------------------------------------------------------------------
module xgmii_pcs_tx_block_fsm
    import xgmii_pcs_tx_block_fsm_pkg::*;
#(
    parameter int XGMII_DATA_W = 64,
    parameter int XGMII_CTRL_W = XGMII_DATA_W / 8,
    parameter int BLOCK_W      = 64,
    parameter int KEEP_W       = BLOCK_W / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    xgmii_v_i,
    input  logic [XGMII_DATA_W-1:0] xgmii_txd_i,
    input  logic [XGMII_CTRL_W-1:0] xgmii_txc_i,
    output logic                    block_v_o,
    output logic                    data_v_o,
    output logic                    ctrl_v_o,
    output logic                    idle_v_o,
    output logic                    start_v_o,
    output logic                    term_v_o,
    output logic                    err_v_o,
    output logic                    start_lane4_o,
    output logic [2:0]              term_lane_o,
    output logic [KEEP_W-1:0]       keep_o,
    output logic                    seq_err_o
);

    logic               asm_v;
    logic [BLOCK_W-1:0] asm_d;
    logic [KEEP_W-1:0]  asm_c;

    generate
        if (XGMII_DATA_W == 32) begin : g_gearbox
            xgmii_gearbox_32_64 #(
                .HALF_W (XGMII_DATA_W),
                .HALF_C (XGMII_CTRL_W)
            ) u_gearbox (
                .clk      (clk),
                .reset    (reset),
                .beat_v_i (xgmii_v_i),
                .beat_d_i (xgmii_txd_i),
                .beat_c_i (xgmii_txc_i),
                .blk_v_o  (asm_v),
                .blk_d_o  (asm_d),
                .blk_c_o  (asm_c)
            );
        end else begin : g_bypass
            assign asm_v = xgmii_v_i & ~reset;
            assign asm_d = xgmii_txd_i;
            assign asm_c = xgmii_txc_i;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Block classification
    // ------------------------------------------------------------------
    blk_class_e cls;
    logic       any_fe;
    logic       all_idle;
    logic       low_idle;
    logic       term_hit;
    logic [2:0] term_k;

    always_comb begin
        any_fe   = 1'b0;
        all_idle = 1'b1;
        low_idle = 1'b1;
        term_hit = 1'b0;
        term_k   = 3'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            // FE is only an error character when it sits in a control lane.
            if (asm_c[i] && (asm_d[8*i +: 8] == XGMII_ERROR)) begin
                any_fe = 1'b1;
            end
            if (asm_d[8*i +: 8] != XGMII_IDLE) begin
                all_idle = 1'b0;
                if (i < 4) begin
                    low_idle = 1'b0;
                end
            end
        end
        for (int k = 0; k < KEEP_W; k++) begin
            if (!term_hit && (asm_c == term_ctrl_mask(3'(k))) &&
                (asm_d[8*k +: 8] == XGMII_TERM)) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end
    end

    always_comb begin
        cls = CLS_ERR;
        if (asm_c == 8'h00) begin
            cls = CLS_DATA;
        end else if (any_fe) begin
            cls = CLS_ERR;
        end else if ((asm_c == 8'hFF) && all_idle) begin
            cls = CLS_IDLE;
        end else if ((asm_c == 8'h01) && (asm_d[7:0] == XGMII_START)) begin
            cls = CLS_START;
        end else if ((asm_c == 8'h1F) && (asm_d[39:32] == XGMII_START) && low_idle) begin
            cls = CLS_START;
        end else if (term_hit) begin
            cls = CLS_TERM;
        end
    end

    // ------------------------------------------------------------------
    // Sequence check
    // ------------------------------------------------------------------
    logic seq_bad;

`ifdef PCS_TX_SEQ_CHECK_EN
    seq_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_INIT;
        end else if (asm_v) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_INIT, SEQ_C: begin
                if (cls == CLS_IDLE)       state_d = SEQ_C;
                else if (cls == CLS_START) state_d = SEQ_D;
                else                       state_d = SEQ_E;
            end
            SEQ_D: begin
                if (cls == CLS_DATA)       state_d = SEQ_D;
                else if (cls == CLS_TERM)  state_d = SEQ_C;
                else                       state_d = SEQ_E;
            end
            SEQ_E: begin
                case (cls)
                    CLS_IDLE, CLS_TERM:  state_d = SEQ_C;
                    CLS_START, CLS_DATA: state_d = SEQ_D;
                    default:             state_d = SEQ_E;
                endcase
            end
            default: state_d = SEQ_INIT;
        endcase
    end

    // Every block that lands in E is flagged, including E -> E on error blocks.
    assign seq_bad = (state_d == SEQ_E);
`else
    assign seq_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic              block_v_q, block_v_d;
    logic              data_v_q, data_v_d;
    logic              ctrl_v_q, ctrl_v_d;
    logic              idle_v_q, idle_v_d;
    logic              start_v_q, start_v_d;
    logic              term_v_q, term_v_d;
    logic              err_v_q, err_v_d;
    logic              lane4_q, lane4_d;
    logic [2:0]        term_lane_q, term_lane_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              seq_err_q, seq_err_d;

    always_comb begin
        block_v_d   = 1'b0;
        seq_err_d   = 1'b0;
        data_v_d    = data_v_q;
        ctrl_v_d    = ctrl_v_q;
        idle_v_d    = idle_v_q;
        start_v_d   = start_v_q;
        term_v_d    = term_v_q;
        err_v_d     = err_v_q;
        lane4_d     = lane4_q;
        term_lane_d = term_lane_q;
        keep_d      = keep_q;
        if (asm_v) begin
            block_v_d   = 1'b1;
            data_v_d    = (cls == CLS_DATA);
            ctrl_v_d    = |asm_c;
            idle_v_d    = (cls == CLS_IDLE);
            start_v_d   = (cls == CLS_START);
            term_v_d    = (cls == CLS_TERM);
            err_v_d     = (cls == CLS_ERR);
            lane4_d     = (cls == CLS_START) && asm_c[4];
            term_lane_d = (cls == CLS_TERM) ? term_k : 3'd0;
            keep_d      = (cls == CLS_DATA) ? '1 :
                          (cls == CLS_TERM) ? ~asm_c : '0;
            if (seq_bad) begin
                // A sequence violation reports the block purely as an error.
                seq_err_d   = 1'b1;
                data_v_d    = 1'b0;
                ctrl_v_d    = 1'b0;
                idle_v_d    = 1'b0;
                start_v_d   = 1'b0;
                term_v_d    = 1'b0;
                err_v_d     = 1'b1;
                lane4_d     = 1'b0;
                term_lane_d = 3'd0;
                keep_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            block_v_q   <= 1'b0;
            data_v_q    <= 1'b0;
            ctrl_v_q    <= 1'b0;
            idle_v_q    <= 1'b0;
            start_v_q   <= 1'b0;
            term_v_q    <= 1'b0;
            err_v_q     <= 1'b0;
            lane4_q     <= 1'b0;
            term_lane_q <= 3'd0;
            keep_q      <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            block_v_q   <= block_v_d;
            data_v_q    <= data_v_d;
            ctrl_v_q    <= ctrl_v_d;
            idle_v_q    <= idle_v_d;
            start_v_q   <= start_v_d;
            term_v_q    <= term_v_d;
            err_v_q     <= err_v_d;
            lane4_q     <= lane4_d;
            term_lane_q <= term_lane_d;
            keep_q      <= keep_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign block_v_o     = block_v_q;
    assign data_v_o      = data_v_q;
    assign ctrl_v_o      = ctrl_v_q;
    assign idle_v_o      = idle_v_q;
    assign start_v_o     = start_v_q;
    assign term_v_o      = term_v_q;
    assign err_v_o       = err_v_q;
    assign start_lane4_o = lane4_q;
    assign term_lane_o   = term_lane_q;
    assign keep_o        = keep_q;
    assign seq_err_o     = seq_err_q;

endmodule
